// File: rtl/cache_init_walker.sv
// -----------------------------------------------------------------------------
// cache_init_walker
//
// Per-bank sequencer for the init side of the cache tag store. It walks every
// line index of the bank and issues one invalidate-init per line so that all
// valid bits and AMO reserve bits are cleared. A sweep runs automatically once
// reset is released and again on every accepted flush request. While a sweep
// is in progress `busy` is high and the bank pipeline must hold off core
// lookups and fills.
//
// Parameters:
//   INSTANCE_ID   debug trace string
//   BANK_ID       bank index used in traces
//   NUM_LINES     lines per bank, power of two, >= 1
//   LINE_SEL_BITS derived line index width; ports use max(LINE_SEL_BITS, 1)
//
// Ports:
//   clk            in   clock
//   reset          in   synchronous, active-high reset
//   flush_valid    in   flush request valid (held by requester until accepted)
//   flush_ready    out  flush accepted when flush_valid && flush_ready
//   init_valid     out  init request to the tag/data store
//   init_line_sel  out  line index to invalidate
//   init_ready     in   store accepts the init this cycle (bank not stalled)
//   busy           out  sweep in progress
//   done           out  one-cycle pulse after the last line is accepted
//   perf_init_cycles out (only with CACHE_INIT_PERF_EN) cycles spent in INIT
//
// Optional feature macro: CACHE_INIT_PERF_EN
//   Adds a 32-bit saturating count of INIT cycles (stalls included). It is
//   cleared at reset and on each flush accept and holds from DONE onward.
//
// All control outputs are registered decodes of the next state, so nothing
// reaches them combinationally from an input.
// -----------------------------------------------------------------------------

// Simulation checker: line index stays in range and done never overlaps an init.
module cache_init_walker_chk #(
  parameter string INSTANCE_ID = "",
  parameter int    BANK_ID     = 0,
  parameter int    NUM_LINES   = 64,
  parameter int    LINE_W      = 6
) (
  input logic              clk,
  input logic              reset,
  input logic              init_valid,
  input logic [LINE_W-1:0] init_line_sel,
  input logic              done
);

  localparam logic [31:0] NUM_LINES_U = NUM_LINES;

  a_line_in_range: assert property (@(posedge clk) disable iff (reset)
    init_valid |-> (32'(init_line_sel) < NUM_LINES_U))
    else $error("%s bank %0d: init_line_sel out of range", INSTANCE_ID, BANK_ID);

  a_done_not_init: assert property (@(posedge clk) disable iff (reset)
    !(done && init_valid))
    else $error("%s bank %0d: done overlaps init_valid", INSTANCE_ID, BANK_ID);

endmodule

module cache_init_walker #(
  parameter string  INSTANCE_ID   = "",
  parameter int     BANK_ID       = 0,
  parameter int     NUM_LINES     = 64,
  localparam int    LINE_SEL_BITS = $clog2(NUM_LINES),
  localparam int    LINE_W        = (LINE_SEL_BITS > 0) ? LINE_SEL_BITS : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_valid,
  output logic              flush_ready,
  output logic              init_valid,
  output logic [LINE_W-1:0] init_line_sel,
  input  logic              init_ready,
  output logic              busy,
  output logic              done
`ifdef CACHE_INIT_PERF_EN
  ,
  output logic [31:0]       perf_init_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);
  localparam logic [LINE_W-1:0] ONE_LINE  = LINE_W'(1);

  state_e            state_q, state_d;
  logic [LINE_W-1:0] cnt_q, cnt_d;
  logic              init_valid_q, init_valid_d;
  logic              busy_q, busy_d;
  logic              flush_ready_q, flush_ready_d;
  logic              done_q, done_d;
  logic              init_fire_s;
  logic              flush_fire_s;

  // Handshakes use the registered valid/ready so a cycle spent in reset never
  // counts as an accepted init or flush.
  assign init_fire_s  = init_valid_q & init_ready;
  assign flush_fire_s = flush_ready_q & flush_valid;

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        // Last-line compare comes before the increment, so the counter
        // never wraps.
        if (init_fire_s) begin
          if (cnt_q == LAST_LINE) begin
            state_d = S_DONE;
            cnt_d   = {LINE_W{1'b0}};
          end else begin
            cnt_d   = cnt_q + ONE_LINE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (flush_fire_s) begin
          state_d = S_INIT;
          cnt_d   = {LINE_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        // Illegal encoding: restart a full sweep so the store ends up clean.
        state_d = S_INIT;
        cnt_d   = {LINE_W{1'b0}};
      end
    endcase

    init_valid_d  = (state_d == S_INIT);
    busy_d        = (state_d == S_INIT);
    flush_ready_d = (state_d == S_IDLE);
    done_d        = (state_d == S_DONE);
  end

  // State, line counter and registered outputs; reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_INIT;
      cnt_q         <= {LINE_W{1'b0}};
      init_valid_q  <= 1'b0;
      busy_q        <= 1'b1;
      flush_ready_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      init_valid_q  <= init_valid_d;
      busy_q        <= busy_d;
      flush_ready_q <= flush_ready_d;
      done_q        <= done_d;
    end
  end

  assign flush_ready   = flush_ready_q;
  assign init_valid    = init_valid_q;
  assign init_line_sel = cnt_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef CACHE_INIT_PERF_EN
  logic [31:0] perf_q, perf_d;

  // INIT cycle counter: every cycle with an init outstanding, stalls included.
  always_comb begin
    perf_d = perf_q;
    if (flush_fire_s) begin
      perf_d = 32'd0;
    end else if (init_valid_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // INIT cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_init_cycles = perf_q;
`endif

  cache_init_walker_chk #(
    .INSTANCE_ID (INSTANCE_ID),
    .BANK_ID     (BANK_ID),
    .NUM_LINES   (NUM_LINES),
    .LINE_W      (LINE_W)
  ) u_chk (
    .clk           (clk),
    .reset         (reset),
    .init_valid    (init_valid_q),
    .init_line_sel (cnt_q),
    .done          (done_q)
  );

endmodule
